// File: rtl/truth_resp_checker.sv
// truth_resp_checker: checks sampled {a,b,c} vectors against TRUTH[{a,b}] and reports pass/fail after NUM_VEC vectors
// Ports: clk, reset (sync, active-high), start, in_valid, in_a/in_b/in_c in;
//        in_ready, busy, done, pass, vec_cnt, err_cnt, first_fail_idx, first_fail_vec, timeout out.
// Optional idle watchdog enabled by CHECKER_TIMEOUT_EN; without it timeout is tied 0.
module truth_resp_checker #(
  parameter logic [3:0] TRUTH   = 4'b1000,
  parameter int         NUM_VEC = 4,
  parameter int         CNT_W   = 8,
  parameter int         TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic go, acc, mis, last, fire;
  assign in_ready = state == RUN;
  assign busy     = state == RUN;
  assign done     = state == DONE;
  assign go       = start && state != RUN;
  assign acc      = in_valid && in_ready;
  assign mis      = in_c != TRUTH[{in_a, in_b}];
  assign last     = vec_cnt == CNT_W'(NUM_VEC - 1);
`ifdef CHECKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  assign fire = in_ready && !acc && idle_cnt == IW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset || go) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (acc) begin
      idle_cnt <= '0;
    end else if (in_ready) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (fire) timeout <= 1'b1;
    end
  end
`else
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = go ? RUN : (in_ready && ((acc && last) || fire)) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset || go) begin
      vec_cnt        <= '0;
      err_cnt        <= '0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (acc) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mis) err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
      if (mis && err_cnt == '0) begin
        first_fail_idx <= vec_cnt;
        first_fail_vec <= {in_a, in_b, in_c};
      end
      if (last) pass <= !mis && err_cnt == '0;
    end
  end
endmodule

// File: tb/tb_truth_resp_checker.sv
// tb_truth_resp_checker: randomized and directed checks of truth_resp_checker against a truth-table model
module tb_truth_resp_checker;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_a = 0, in_b = 0, in_c = 0;
  logic a_ready, a_busy, a_done, a_pass, a_to;
  logic x_ready, x_busy, x_done, x_pass, x_to;
  logic [7:0] a_vec, a_err, a_idx, x_vec, x_err, x_idx;
  logic [2:0] a_fv, x_fv;
  int n_chk = 0, n_fail = 0;

  truth_resp_checker u_and (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_ready(a_ready), .busy(a_busy),
    .done(a_done), .pass(a_pass), .vec_cnt(a_vec), .err_cnt(a_err),
    .first_fail_idx(a_idx), .first_fail_vec(a_fv), .timeout(a_to));

  truth_resp_checker #(.TRUTH(4'b0110)) u_xor (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_ready(x_ready), .busy(x_busy),
    .done(x_done), .pass(x_pass), .vec_cnt(x_vec), .err_cnt(x_err),
    .first_fail_idx(x_idx), .first_fail_vec(x_fv), .timeout(x_to));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_c(input bit x, input logic [2:0] v);
    return x ? (v[2] ^ v[1]) : (v[2] & v[1]);
  endfunction

  task automatic model(input logic [2:0] v [4], input bit x, output int err, output int idx, output logic [2:0] fv);
    err = 0; idx = 0; fv = 3'b000;
    for (int i = 0; i < 4; i++)
      if (v[i][0] != exp_c(x, v[i])) begin
        if (err == 0) begin idx = i; fv = v[i]; end
        err++;
      end
  endtask

  task automatic do_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push(input logic [2:0] v);
    in_valid = 1;
    {in_a, in_b, in_c} = v;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_ready, a_busy, a_done, a_pass, a_vec, a_err, a_idx, a_fv, a_to} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", {a_ready, a_busy, a_done, a_pass, a_vec, a_err, a_idx, a_fv, a_to});
    end
    reset = 0;
    push(3'b001);
    n_chk++;
    if ({a_busy, a_done, a_vec, a_err} !== 18'd0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: busy=%b done=%b vec=%0d err=%0d required all 0", a_busy, a_done, a_vec, a_err);
    end
  endtask

  task automatic test_all_pass;
    logic [2:0] v [4] = '{3'b000, 3'b010, 3'b100, 3'b111};
    do_start;
    n_chk++;
    if ({a_busy, a_ready, a_done, a_vec} !== {3'b110, 8'd0}) begin
      n_fail++;
      $display("FAIL run_entry: busy=%b ready=%b done=%b vec=%0d required 1 1 0 0", a_busy, a_ready, a_done, a_vec);
    end
    for (int i = 0; i < 4; i++) push(v[i]);
    n_chk++;
    if ({a_done, a_pass, a_ready, a_vec, a_err} !== {3'b110, 8'd4, 8'd0}) begin
      n_fail++;
      $display("FAIL all_pass: done=%b pass=%b ready=%b vec=%0d err=%0d required 1 1 0 4 0", a_done, a_pass, a_ready, a_vec, a_err);
    end
    n_chk++;
    if ({a_idx, a_fv} !== 11'd0) begin
      n_fail++;
      $display("FAIL all_pass_first: idx=%0d vec=%b required 0 000", a_idx, a_fv);
    end
  endtask

  task automatic test_mismatch;
    logic [2:0] v [4] = '{3'b000, 3'b010, 3'b101, 3'b111};
    do_start;
    for (int i = 0; i < 4; i++) push(v[i]);
    n_chk++;
    if ({a_done, a_pass, a_vec, a_err, a_idx, a_fv} !== {2'b10, 8'd4, 8'd1, 8'd2, 3'b101}) begin
      n_fail++;
      $display("FAIL mismatch: done=%b pass=%b vec=%0d err=%0d idx=%0d fv=%b required 1 0 4 1 2 101",
               a_done, a_pass, a_vec, a_err, a_idx, a_fv);
    end
  endtask

  task automatic test_hold_valid;
    do_start;
    in_valid = 1;
    {in_a, in_b, in_c} = 3'b111;
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (a_ready !== (k < 4) || a_done !== (k >= 4)) begin
        n_fail++;
        $display("FAIL hold_valid_cycle%0d: ready=%b done=%b required %b %b", k, a_ready, a_done, k < 4, k >= 4);
      end
      @(negedge clk);
    end
    in_valid = 0;
    n_chk++;
    if ({a_vec, a_pass} !== {8'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_valid_count: vec=%0d pass=%b required 4 1", a_vec, a_pass);
    end
  endtask

  task automatic test_reset_mid;
    do_start;
    push(3'b000);
    push(3'b011);
    n_chk++;
    if ({a_vec, a_err} !== {8'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_count: vec=%0d err=%0d required 2 1", a_vec, a_err);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_chk++;
    if ({a_busy, a_done, a_vec, a_err, a_idx, a_fv} !== 29'd0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b vec=%0d err=%0d idx=%0d fv=%b required all 0",
               a_busy, a_done, a_vec, a_err, a_idx, a_fv);
    end
    do_start;
    for (int i = 0; i < 4; i++) push({i[1:0], i == 3 ? 1'b1 : 1'b0});
    n_chk++;
    if ({a_done, a_pass, a_vec, a_err} !== {2'b11, 8'd4, 8'd0}) begin
      n_fail++;
      $display("FAIL after_reset_run: done=%b pass=%b vec=%0d err=%0d required 1 1 4 0", a_done, a_pass, a_vec, a_err);
    end
  endtask

  task automatic test_xor_inverted;
    logic [2:0] v [4];
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab = 2'($urandom_range(3));
      v[i] = {ab, ~(ab[1] ^ ab[0])};
    end
    do_start;
    for (int i = 0; i < 4; i++) push(v[i]);
    n_chk++;
    if ({x_done, x_pass, x_vec, x_err, x_idx, x_fv} !== {2'b10, 8'd4, 8'd4, 8'd0, v[0]}) begin
      n_fail++;
      $display("FAIL xor_inverted: done=%b pass=%b vec=%0d err=%0d idx=%0d fv=%b required 1 0 4 4 0 %b",
               x_done, x_pass, x_vec, x_err, x_idx, x_fv, v[0]);
    end
  endtask

  task automatic test_random;
    logic [2:0] v [4];
    int ae, ai, xe, xi;
    logic [2:0] af, xf;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) v[i] = 3'($urandom_range(7));
      model(v, 1'b0, ae, ai, af);
      model(v, 1'b1, xe, xi, xf);
      do_start;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(2)) begin
          start = ($urandom_range(1) == 1);
          @(negedge clk);
          start = 0;
        end
        push(v[i]);
      end
      n_chk++;
      if ({a_done, a_pass, a_vec, a_err, a_idx, a_fv} !== {1'b1, ae == 0, 8'd4, 8'(ae), 8'(ai), af}) begin
        n_fail++;
        $display("FAIL rand_and_run%0d: pass=%b vec=%0d err=%0d idx=%0d fv=%b required %b 4 %0d %0d %b",
                 r, a_pass, a_vec, a_err, a_idx, a_fv, ae == 0, ae, ai, af);
      end
      n_chk++;
      if ({x_done, x_pass, x_vec, x_err, x_idx, x_fv} !== {1'b1, xe == 0, 8'd4, 8'(xe), 8'(xi), xf}) begin
        n_fail++;
        $display("FAIL rand_xor_run%0d: pass=%b vec=%0d err=%0d idx=%0d fv=%b required %b 4 %0d %0d %b",
                 r, x_pass, x_vec, x_err, x_idx, x_fv, xe == 0, xe, xi, xf);
      end
      push(~v[0]);
      n_chk++;
      if ({a_done, a_vec, a_err, a_pass} !== {1'b1, 8'd4, 8'(ae), ae == 0}) begin
        n_fail++;
        $display("FAIL done_hold%0d: done=%b vec=%0d err=%0d pass=%b required 1 4 %0d %b", r, a_done, a_vec, a_err, a_pass, ae, ae == 0);
      end
    end
  endtask

  task automatic test_timeout;
    do_start;
    push(3'b111);
`ifdef CHECKER_TIMEOUT_EN
    repeat (15) @(negedge clk);
    n_chk++;
    if ({a_done, a_to, a_busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout_early: done=%b timeout=%b busy=%b required 0 0 1", a_done, a_to, a_busy);
    end
    @(negedge clk);
    n_chk++;
    if ({a_done, a_to, a_pass, a_vec} !== {3'b110, 8'd1}) begin
      n_fail++;
      $display("FAIL timeout_fire: done=%b timeout=%b pass=%b vec=%0d required 1 1 0 1", a_done, a_to, a_pass, a_vec);
    end
    do_start;
    n_chk++;
    if ({a_busy, a_to, a_vec} !== {2'b10, 8'd0}) begin
      n_fail++;
      $display("FAIL timeout_restart: busy=%b timeout=%b vec=%0d required 1 0 0", a_busy, a_to, a_vec);
    end
`else
    repeat (20) @(negedge clk);
    n_chk++;
    if ({a_busy, a_done, a_to, a_vec} !== {3'b100, 8'd1}) begin
      n_fail++;
      $display("FAIL no_watchdog_wait: busy=%b done=%b timeout=%b vec=%0d required 1 0 0 1", a_busy, a_done, a_to, a_vec);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_all_pass;
    test_mismatch;
    test_hold_valid;
    test_reset_mid;
    test_xor_inverted;
    test_random;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
